// File: rtl/console_pkg.sv
// Shared types and constants for the console UART transmitter.
// Holds the serializer state encoding and default sizing.
package console_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   localparam logic [7:0] ASCII_NL = 8'h0A;

   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int FIFO_DEPTH_DEF   = 16;

endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO with push/pop handshake and level count.
// Full and empty are derived from the level counter, not the pointers.
module char_fifo
   import console_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // storage array, written on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointers wrap naturally; level tracks push minus pop
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            level <= level + LVL_W'(1);
         end else if (do_pop && !do_push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

endmodule

// File: rtl/console_uart_tx.sv
// Console UART transmitter: buffers print-stage bytes, sends 8N1 on tx.
// Back-to-back frames are contiguous when the buffer stays non-empty.
module console_uart_tx
   import console_pkg::*;
#(
   parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       char_in,
   input  logic             char_valid,
   output logic             char_ready,
   output logic             tx,
   output logic             busy,
   output logic [LVL_W-1:0] fifo_level,
   output logic             nl_sent
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic             is_nl;
   logic             is_nl_nxt;
   logic             pop;
   logic             tick;
   logic [7:0]       fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] level;

   char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (char_valid),
      .wdata (char_in),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign tick       = (cnt == CNT_LAST);
   assign char_ready = !fifo_full;
   assign fifo_level = level;
   assign busy       = (state != S_IDLE) || (level != '0);

   // serializer state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         is_nl   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shift   <= shift_nxt;
         is_nl   <= is_nl_nxt;
      end
   end

   // next-state, pop request and line/pulse outputs
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      is_nl_nxt = is_nl;
      pop       = 1'b0;
      nl_sent   = 1'b0;
      tx        = 1'b1;
      unique case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            tx      = 1'b0;
            cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
               bit_nxt   = '0;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            tx      = shift[0];
            cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
               shift_nxt = {1'b0, shift[7:1]};
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            tx      = 1'b1;
            cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
               nl_sent = is_nl;
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (pop) begin
         shift_nxt = fifo_rdata;
         is_nl_nxt = (fifo_rdata == ASCII_NL);
         cnt_nxt   = '0;
      end
   end

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx with a line receiver model.
// Table vectors, directed corner sequences and random traffic.
module tb_console_uart_tx;
   import console_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;
   localparam int FRAME = 10 * CPB;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       char_in = 8'h00;
   logic             char_valid = 1'b0;
   logic             char_ready;
   logic             tx;
   logic             busy;
   logic [LVL_W-1:0] fifo_level;
   logic             nl_sent;

   int         checks = 0;
   int         errors = 0;
   int         rx_count = 0;
   logic [7:0] exp_q [$];
   bit         saw_full = 0;
   bit         saw_block = 0;

   typedef struct {
      logic [7:0] ch;
      logic [9:0] frame;
      logic       nl;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   console_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_level (fifo_level),
      .nl_sent    (nl_sent)
   );

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // model: bytes accepted by the buffer, in order
   always @(posedge clk) begin
      if (reset) exp_q.delete();
      else if (char_valid && char_ready) exp_q.push_back(char_in);
   end

   // receiver model: decode each frame from the line and check it
   initial begin : monitor
      logic [FRAME-1:0] samp;
      logic [FRAME-1:0] nlv;
      logic [FRAME-1:0] nl_exp;
      logic [7:0]       b;
      logic [7:0]       e;
      bit               ok;
      bit               in_frame;
      int               k;
      in_frame = 0;
      k = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_frame = 0;
         end else if (!in_frame) begin
            if (tx === 1'b0) begin
               samp = '0;
               nlv = '0;
               nlv[0] = nl_sent;
               in_frame = 1;
               k = 1;
            end else begin
               chk("nl_idle", nl_sent, 0);
            end
         end else begin
            samp[k] = tx;
            nlv[k] = nl_sent;
            k++;
            if (k == FRAME) begin
               in_frame = 0;
               ok = 1;
               for (int bi = 0; bi < 10; bi++)
                  for (int c = 1; c < CPB; c++)
                     if (samp[bi*CPB+c] !== samp[bi*CPB]) ok = 0;
               if (samp[9*CPB] !== 1'b1) ok = 0;
               for (int i = 0; i < 8; i++) b[i] = samp[(i+1)*CPB];
               chk("rx_fmt", ok, 1);
               chk("rx_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  nl_exp = '0;
                  nl_exp[FRAME-1] = (e == ASCII_NL);
                  chk("rx_byte", b, e);
                  chk("rx_nl", nlv, nl_exp);
               end
               rx_count++;
            end
         end
      end
   end

   // cycle-exact line check; called at the negedge where start is low
   task automatic check_frames(input logic [29:0] frames,
                               input logic [2:0] nls, input int n);
      int idx;
      int pos;
      for (int k = 0; k < n * FRAME; k++) begin
         if (k > 0) @(negedge clk);
         idx = k / FRAME;
         pos = (k % FRAME) / CPB;
         chk($sformatf("tx_k%0d", k), tx, frames[idx*10+pos]);
         chk($sformatf("nl_k%0d", k), nl_sent,
             (k % FRAME == FRAME - 1) && nls[idx]);
         chk("busy_frame", busy, 1);
      end
      @(negedge clk);
      chk("busy_drop", busy, 0);
      chk("tx_after", tx, 1);
   endtask

   task automatic push_single(input logic [7:0] b);
      @(posedge clk);
      #1 char_in = b;
      char_valid = 1'b1;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(negedge clk);
      chk("lat_pre_tx", tx, 1);
      chk("lat_pre_lvl", fifo_level, 1);
      chk("lat_pre_busy", busy, 1);
      @(negedge clk);
      chk("lat_fall", tx, 0);
   endtask

   // hold valid and data until accepted; called at posedge+1
   task automatic push_hold(input logic [7:0] b);
      bit acc;
      int w;
      acc = 0;
      w = 0;
      char_in = b;
      char_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = char_ready;
         if (fifo_level == LVL_W'(DEPTH)) saw_full = 1;
         if (!acc) saw_block = 1;
         chk("ready_vs_full", char_ready, fifo_level != LVL_W'(DEPTH));
         @(posedge clk);
         #1 w++;
      end while (!acc && w < 400);
      chk("hold_accept", acc, 1);
      char_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < lim);
      chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_fall(input int lim);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < lim);
      chk("fall_timeout", tx, 0);
   endtask

   initial begin
      int base;
      vecs[0] = '{8'h48, 10'b1_0100_1000_0, 1'b0};
      vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
      vecs[2] = '{8'h0A, 10'b1_0000_1010_0, 1'b1};
      vecs[3] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
      vecs[4] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
      vecs[5] = '{8'h80, 10'b1_1000_0000_0, 1'b0};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_state", {tx, busy, char_ready, fifo_level},
             {3'b101, {LVL_W{1'b0}}});
      end

      for (int i = 0; i < 6; i++) begin
         push_single(vecs[i].ch);
         check_frames({20'b0, vecs[i].frame}, {2'b0, vecs[i].nl}, 1);
      end

      fork
         begin
            char_in = 8'h48;
            char_valid = 1'b1;
            @(posedge clk);
            #1 char_in = 8'h69;
            @(posedge clk);
            #1 char_in = 8'h0A;
            @(posedge clk);
            #1 char_valid = 1'b0;
         end
         begin
            @(negedge clk);
            chk("hi_pre", tx, 1);
            @(negedge clk);
            chk("hi_fall", tx, 0);
            check_frames({1'b1, 8'h0A, 1'b0, 1'b1, 8'h69, 1'b0,
                          1'b1, 8'h48, 1'b0}, 3'b100, 3);
         end
      join

      base = rx_count;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) push_hold(8'h41 + 8'(i));
      wait_idle(1000);
      chk("hold_frames", rx_count - base, 8);
      chk("hold_q_empty", exp_q.size(), 0);
      chk("hold_saw_full", saw_full, 1);
      chk("hold_saw_block", saw_block, 1);

      fork
         begin
            @(posedge clk);
            #1 char_in = 8'h55;
            char_valid = 1'b1;
            @(posedge clk);
            #1 char_in = 8'h31;
            @(posedge clk);
            #1 char_in = 8'h32;
            @(posedge clk);
            #1 char_valid = 1'b0;
         end
         begin
            wait_fall(10);
            repeat (17) @(negedge clk);
            chk("rst_bit3", tx, 0);
            chk("rst_lvl_pre", fifo_level, 2);
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("rst_tx", tx, 1);
            chk("rst_lvl", fifo_level, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", char_ready, 1);
            @(posedge clk);
            #1 reset = 1'b0;
         end
      join
      base = rx_count;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("post_rst", {tx, busy, fifo_level}, {2'b10, {LVL_W{1'b0}}});
      end
      chk("post_rst_rx", rx_count - base, 0);

      base = rx_count;
      @(posedge clk);
      #1;
      for (int i = 0; i < 25; i++) begin
         int gap;
         logic [7:0] rb;
         gap = $urandom_range(0, 50);
         repeat (gap) @(posedge clk);
         #1;
         rb = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
         push_hold(rb);
      end
      wait_idle(3000);
      chk("rand_frames", rx_count - base, 25);
      chk("rand_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Downstream consumer of the string-print stage: it takes the ASCII characters that stage emits, one byte per handshake, and turns them into an 8N1 serial stream on a single `tx` pin.
- A small synchronous FIFO decouples the burst-rate character producer from the slow bit-rate serializer.
- This replaces simulation-only `$write` console output with synthesizable hardware, so the processor can print to a real terminal.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2).
- FIFO_DEPTH, 16, character buffer entries (power of two, ≥2).
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- char_in  in  8  ASCII byte from the print stage.
- char_valid  in  1  char_in valid this cycle.
- char_ready  out  1  buffer can accept; transfer occurs when char_valid && char_ready.
- tx  out  1  serial line, idle high.
- busy  out  1  FIFO non-empty or frame in progress.
- fifo_level  out  LVL_W  entries currently buffered.
- nl_sent  out  1  one-cycle pulse when the stop bit of a 0x0A byte completes.

Behaviour:
- Reset values: tx=1, char_ready=1, busy=0, fifo_level=0, nl_sent=0. FSM returns to IDLE, FIFO pointers are cleared, bit and cycle counters are zeroed.
- Reset mid-frame aborts the frame: tx=1 from the cycle after the reset edge, and buffered data is discarded.
- Handshake: `char_ready = !full`, computed combinationally from registered state. A push at edge E writes the FIFO; fifo_level increments after E.
- Full FIFO: char_ready=0 and no write occurs. The producer must hold char_valid and char_in stable until ready.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO not empty, pop into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit. Shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, if FIFO not empty, pop and go to START (no idle gap); otherwise go to IDLE. nl_sent pulses on this cycle if the byte was 0x0A.
- Latency: a byte pushed at edge E0 into an empty FIFO with FSM in IDLE is popped at E1. tx falls in the cycle after E1.
- Frame length: exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Simultaneous push and pop:
  - Allowed whenever not full; fifo_level is unchanged.
  - At full, a pop and a push on the same edge is not permitted, because ready is already 0.
  - At empty, no pop occurs, so the new byte is popped on the following cycle.
- Counters:
  - Cycle counter width $clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits with natural wrap. Full/empty come from the level counter.
- `busy = (state != IDLE) || (fifo_level != 0)`.
- No byte filtering: 0x00 is transmitted like any other byte. Null suppression is the producer's job.

Decomposition:
- Shared package `console_pkg`:
  - State encoding localparams: S_IDLE=2'd0, S_START=2'd1, S_DATA=2'd2, S_STOP=2'd3.
  - ASCII_NL=8'h0A.
  - Default CLKS_PER_BIT and FIFO_DEPTH.
- One sub-module, `char_fifo`: a parameterized synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/level and synchronous reset. The serializer FSM stays in console_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then idle 50 cycles -> tx=1, busy=0, char_ready=1, fifo_level=0 throughout.
- Push 0x48 ('H') once -> tx low exactly 1 cycle after the pop edge, for 4 cycles. Then bits 0,0,0,1,0,0,1,0 (LSB first), 4 cycles each, then stop high 4 cycles. Frame is 40 cycles; busy drops the cycle after the stop ends.
- Push "Hi\n" (0x48,0x69,0x0A) on consecutive cycles -> three contiguous 40-cycle frames with no idle between them. nl_sent pulses once, at the end of the third stop bit.
- Hold char_valid=1 with 8 bytes 0x41..0x48 -> char_ready deasserts when fifo_level=4 and reasserts after each pop. All 8 bytes are serialized in order with none lost or duplicated.
- Assert reset during DATA bit 3 of 0x55 with 2 bytes queued -> next cycle tx=1, fifo_level=0, busy=0. No further frames until a new push.
- Push 0x00 -> full frame: start bit, eight 0 data bits, stop bit. nl_sent stays 0.
